// File: rtl/cca_pkg.sv
// Shared types and constants for the chromatic-adaptation matrix sequencer.
// Matrices are nine row-major Q16.16 elements; element k lives at [32k+31:32k].
package cca_pkg;

  localparam logic [31:0] Q16_ONE  = 32'h0001_0000;
  localparam int          MATRIX_W = 288;
  localparam int          XYZ_W    = 96;

  localparam logic [MATRIX_W-1:0] IDENTITY_MATRIX =
    {Q16_ONE, 96'h0, Q16_ONE, 96'h0, Q16_ONE};

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    REQUEST     = 2'd1,
    WAIT_MATRIX = 2'd2,
    PENDING     = 2'd3
  } cca_state_e;

  // Bit offset of matrix element (row, col) inside the packed 288-bit bus.
  function automatic int unsigned elem_lsb(input int unsigned row, input int unsigned col);
    return 32 * (3 * row + col);
  endfunction

endpackage

// File: rtl/cca_matrix_sequencer_if.sv
// Bus bundle between the sequencer, the ambient sensor path, the Bradford
// block and the image processor. The sequencer uses the slave modport.
interface cca_matrix_sequencer_if;

  logic [cca_pkg::XYZ_W-1:0]    sensor_xyz;
  logic                         sensor_valid;
  logic                         sensor_ready;
  logic [15:0]                  ref_cct;

  logic [cca_pkg::XYZ_W-1:0]    brad_xyz;
  logic [15:0]                  brad_cct;
  logic                         brad_xyz_valid;
  logic [cca_pkg::MATRIX_W-1:0] brad_matrix;
  logic                         brad_matrix_valid;

  logic                         frame_sync;
  logic                         proc_busy;
  logic [cca_pkg::MATRIX_W-1:0] proc_matrix;
  logic                         proc_matrix_valid;

  logic [15:0]                  update_count;
  logic [7:0]                   superseded_count;
  logic                         timeout_err;

  modport slave (
    input  sensor_xyz, sensor_valid, ref_cct,
    input  brad_matrix, brad_matrix_valid,
    input  frame_sync, proc_busy,
    output sensor_ready,
    output brad_xyz, brad_cct, brad_xyz_valid,
    output proc_matrix, proc_matrix_valid,
    output update_count, superseded_count, timeout_err
  );

  modport master (
    output sensor_xyz, sensor_valid, ref_cct,
    output brad_matrix, brad_matrix_valid,
    output frame_sync, proc_busy,
    input  sensor_ready,
    input  brad_xyz, brad_cct, brad_xyz_valid,
    input  proc_matrix, proc_matrix_valid,
    input  update_count, superseded_count, timeout_err
  );

endinterface

// File: rtl/cca_watchdog.sv
// Calculation watchdog: 16-bit down-counter reloaded while cleared, flags
// expiry on the TIMEOUT-th enabled cycle.
module cca_watchdog #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LOAD = 16'(TIMEOUT - 1);

  logic [15:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= LOAD;
    end else if (clear) begin
      count <= LOAD;
    end else if (enable && (count != 16'd0)) begin
      count <= count - 16'd1;
    end
  end

  // count holds the cycles still allowed, so zero means this is the last one.
  assign expired = enable && (count == 16'd0);

endmodule

// File: rtl/cca_matrix_sequencer.sv
// Sequences Bradford matrix requests and commits results at frame boundaries.
// Optional macro CCA_RESET_IDENTITY_EN: reset loads an identity proc_matrix.
//
// state       | meaning
// ------------+---------------------------------------------------------
// IDLE        | no work outstanding, ready for an ambient sample
// REQUEST     | one-cycle brad_xyz_valid pulse to the Bradford block
// WAIT_MATRIX | waiting for brad_matrix_valid, watchdog running
// PENDING     | shadow matrix held until a frame boundary with proc idle
module cca_matrix_sequencer
  import cca_pkg::*;
#(
  parameter int unsigned MATRIX_TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cca_matrix_sequencer_if.slave  bus
);

`ifdef CCA_RESET_IDENTITY_EN
  localparam logic [MATRIX_W-1:0] PROC_RESET_MATRIX = IDENTITY_MATRIX;
  localparam logic                PROC_RESET_VALID  = 1'b1;
`else
  localparam logic [MATRIX_W-1:0] PROC_RESET_MATRIX = '0;
  localparam logic                PROC_RESET_VALID  = 1'b0;
`endif

  cca_state_e state;
  cca_state_e next_state;

  logic sensor_ready;
  logic accept;
  logic supersede;
  logic capture;
  logic abort;
  logic commit;
  logic wd_expired;
  logic in_wait;

  logic [XYZ_W-1:0]    brad_xyz;
  logic [15:0]         brad_cct;
  logic                brad_xyz_valid;
  logic [MATRIX_W-1:0] shadow;
  logic [MATRIX_W-1:0] proc_matrix;
  logic                proc_matrix_valid;
  logic [15:0]         update_count;
  logic [7:0]          superseded_count;
  logic                timeout_err;

  assign in_wait = (state == WAIT_MATRIX);

  cca_watchdog #(
    .TIMEOUT (MATRIX_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!in_wait),
    .enable  (in_wait),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) next_state = REQUEST;
      end
      REQUEST: begin
        next_state = WAIT_MATRIX;
      end
      WAIT_MATRIX: begin
        if (capture)    next_state = PENDING;
        else if (abort) next_state = IDLE;
      end
      PENDING: begin
        if (commit)      next_state = IDLE;
        else if (accept) next_state = REQUEST;
      end
      default: next_state = IDLE;
    endcase
  end

  // Commit is decoded first so that it blocks a same-cycle sensor accept.
  always_comb begin
    sensor_ready = 1'b0;
    capture      = 1'b0;
    abort        = 1'b0;
    commit       = 1'b0;
    case (state)
      IDLE: begin
        sensor_ready = 1'b1;
      end
      WAIT_MATRIX: begin
        capture = bus.brad_matrix_valid;
        abort   = !bus.brad_matrix_valid && wd_expired;
      end
      PENDING: begin
        commit       = bus.frame_sync && !bus.proc_busy;
        sensor_ready = !commit;
      end
      default: ;
    endcase
    accept    = bus.sensor_valid && sensor_ready;
    supersede = accept && (state == PENDING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brad_xyz          <= '0;
      brad_cct          <= '0;
      brad_xyz_valid    <= 1'b0;
      shadow            <= '0;
      proc_matrix       <= PROC_RESET_MATRIX;
      proc_matrix_valid <= PROC_RESET_VALID;
      update_count      <= '0;
      superseded_count  <= '0;
      timeout_err       <= 1'b0;
    end else begin
      brad_xyz_valid <= accept;

      if (accept) begin
        brad_xyz <= bus.sensor_xyz;
        brad_cct <= bus.ref_cct;
      end

      if (capture) begin
        shadow <= bus.brad_matrix;
      end else if (abort || supersede) begin
        shadow <= '0;
      end

      if (supersede && (superseded_count != 8'hFF)) begin
        superseded_count <= superseded_count + 8'd1;
      end

      if (commit) begin
        proc_matrix       <= shadow;
        proc_matrix_valid <= 1'b1;
        update_count      <= update_count + 16'd1;
        timeout_err       <= 1'b0;
      end else if (abort) begin
        timeout_err <= 1'b1;
      end
    end
  end

  assign bus.sensor_ready      = sensor_ready;
  assign bus.brad_xyz          = brad_xyz;
  assign bus.brad_cct          = brad_cct;
  assign bus.brad_xyz_valid    = brad_xyz_valid;
  assign bus.proc_matrix       = proc_matrix;
  assign bus.proc_matrix_valid = proc_matrix_valid;
  assign bus.update_count      = update_count;
  assign bus.superseded_count  = superseded_count;
  assign bus.timeout_err       = timeout_err;

endmodule

// File: tb/tb_cca_matrix_sequencer.sv
// Directed vector bench for cca_matrix_sequencer with MATRIX_TIMEOUT=16.
// Honours CCA_RESET_IDENTITY_EN for the expected reset matrix.
module tb_cca_matrix_sequencer;
  import cca_pkg::*;

`ifdef CCA_RESET_IDENTITY_EN
  localparam logic [MATRIX_W-1:0] RST_PM  = IDENTITY_MATRIX;
  localparam logic                RST_PMV = 1'b1;
`else
  localparam logic [MATRIX_W-1:0] RST_PM  = '0;
  localparam logic                RST_PMV = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cca_matrix_sequencer_if bus ();

  cca_matrix_sequencer #(
    .MATRIX_TIMEOUT (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // One cycle of stimulus plus what must be seen: e_rdy before the edge,
  // everything else just after it. Index -1 for e_pm means the reset matrix.
  typedef struct {
    int sv, xs, bmv, ms, fs, pb;
    int e_rdy, e_req, e_xs, e_pm, e_upd, e_sup, e_to;
  } vec_t;

  logic [MATRIX_W-1:0] mats [4];
  logic [XYZ_W-1:0]    xyzs [3];
  logic [15:0]         ccts [3];
  vec_t                vecs [$];
  int                  pass_cnt  = 0;
  int                  total_cnt = 0;

  function automatic vec_t mk(input int sv, xs, bmv, ms, fs, pb,
                              input int e_rdy, e_req, e_xs, e_pm, e_upd, e_sup, e_to);
    vec_t v;
    v.sv = sv; v.xs = xs; v.bmv = bmv; v.ms = ms; v.fs = fs; v.pb = pb;
    v.e_rdy = e_rdy; v.e_req = e_req; v.e_xs = e_xs; v.e_pm = e_pm;
    v.e_upd = e_upd; v.e_sup = e_sup; v.e_to = e_to;
    return v;
  endfunction

  function automatic logic [MATRIX_W-1:0] pm_exp(input int idx);
    return (idx < 0) ? RST_PM : mats[idx];
  endfunction

  task automatic chk(input string name, input logic [MATRIX_W-1:0] act,
                     input logic [MATRIX_W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_outs(input vec_t v);
    chk("brad_xyz_valid",    MATRIX_W'(bus.brad_xyz_valid),    MATRIX_W'(v.e_req));
    chk("brad_xyz",          MATRIX_W'(bus.brad_xyz),          MATRIX_W'(xyzs[v.e_xs]));
    chk("brad_cct",          MATRIX_W'(bus.brad_cct),          MATRIX_W'(ccts[v.e_xs]));
    chk("proc_matrix",       bus.proc_matrix,                  pm_exp(v.e_pm));
    chk("proc_matrix_valid", MATRIX_W'(bus.proc_matrix_valid),
        MATRIX_W'((v.e_pm < 0) ? RST_PMV : 1'b1));
    chk("update_count",      MATRIX_W'(bus.update_count),      MATRIX_W'(v.e_upd));
    chk("superseded_count",  MATRIX_W'(bus.superseded_count),  MATRIX_W'(v.e_sup));
    chk("timeout_err",       MATRIX_W'(bus.timeout_err),       MATRIX_W'(v.e_to));
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    bus.sensor_valid      = v.sv[0];
    bus.sensor_xyz        = xyzs[v.xs];
    bus.ref_cct           = ccts[v.xs];
    bus.brad_matrix_valid = v.bmv[0];
    bus.brad_matrix       = mats[v.ms];
    bus.frame_sync        = v.fs[0];
    bus.proc_busy         = v.pb[0];
    #1;
    chk("sensor_ready", MATRIX_W'(bus.sensor_ready), MATRIX_W'(v.e_rdy));
    @(posedge clk);
    #1;
    check_outs(v);
  endtask

  initial begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        mats[0][elem_lsb(r, c) +: 32] = 32'h0;
        mats[1][elem_lsb(r, c) +: 32] = 32'h0000_1000 * (3 * r + c + 1);
        mats[2][elem_lsb(r, c) +: 32] = 32'h0002_0000 + 32'(3 * r + c);
        mats[3][elem_lsb(r, c) +: 32] = 32'hFFFF_0000 - 32'(3 * r + c);
      end
    end
    xyzs[0] = '0;
    xyzs[1] = {32'h0001_1666, 32'h0001_0000, 32'h0000_F333};
    xyzs[2] = {32'h0000_5A3D, 32'h0001_0000, 32'h0001_0FB1};
    ccts[0] = 16'd0;
    ccts[1] = 16'd6500;
    ccts[2] = 16'd2856;

    bus.sensor_valid = 1'b0; bus.sensor_xyz = '0; bus.ref_cct = '0;
    bus.brad_matrix_valid = 1'b0; bus.brad_matrix = '0;
    bus.frame_sync = 1'b0; bus.proc_busy = 1'b0;

    //        sv xs bm ms fs pb   rdy req exs pm upd sup to
    // D65 sample, capture on first WAIT edge, commit on first idle frame_sync
    vecs.push_back(mk(1, 1, 0, 0, 0, 0,  1, 1, 1, -1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, -1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0,  0, 0, 1, -1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0,  0, 0, 1,  1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 3, 1, 0,  1, 0, 1,  1, 1, 0, 0));
    // frame_sync on capture edge and while busy must not commit
    vecs.push_back(mk(1, 2, 0, 0, 0, 0,  1, 1, 2,  1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 2,  1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 2,  1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 2, 1, 0,  0, 0, 2,  1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 3, 1, 1,  1, 0, 2,  1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, 0, 2,  1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0,  0, 0, 2,  2, 2, 0, 0));
    // second sample supersedes a pending matrix
    vecs.push_back(mk(1, 1, 0, 0, 0, 0,  1, 1, 1,  2, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1,  2, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 3, 0, 0,  0, 0, 1,  2, 2, 0, 0));
    vecs.push_back(mk(1, 2, 0, 0, 0, 0,  1, 1, 2,  2, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 2,  2, 2, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0,  0, 0, 2,  2, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0,  0, 0, 2,  1, 3, 1, 0));
    // commit beats a same-cycle sample, which is then taken next cycle
    vecs.push_back(mk(1, 1, 0, 0, 0, 0,  1, 1, 1,  1, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1,  1, 3, 1, 0));
    vecs.push_back(mk(0, 0, 1, 2, 0, 0,  0, 0, 1,  1, 3, 1, 0));
    vecs.push_back(mk(1, 2, 0, 0, 1, 0,  0, 0, 1,  2, 4, 1, 0));
    vecs.push_back(mk(1, 2, 0, 0, 0, 0,  1, 1, 2,  2, 4, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 2,  2, 4, 1, 0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset sensor_ready", MATRIX_W'(bus.sensor_ready), MATRIX_W'(1));
    check_outs(mk(0, 0, 0, 0, 0, 0,  1, 0, 0, -1, 0, 0, 0));

    foreach (vecs[i]) apply(vecs[i]);

    // Watchdog: the last table row left the FSM in WAIT_MATRIX.
    for (int k = 1; k <= 16; k++) begin
      apply(mk(0, 0, 0, 0, 0, 0,  0, 0, 2, 2, 4, 1, (k == 16) ? 1 : 0));
    end
    apply(mk(1, 1, 0, 0, 0, 0,  1, 1, 1, 2, 4, 1, 1));
    apply(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 2, 4, 1, 1));
    apply(mk(0, 0, 1, 3, 0, 0,  0, 0, 1, 2, 4, 1, 1));
    apply(mk(0, 0, 0, 0, 1, 0,  0, 0, 1, 3, 5, 1, 0));

    // Reset while in WAIT_MATRIX abandons the request.
    apply(mk(1, 2, 0, 0, 0, 0,  1, 1, 2, 3, 5, 1, 0));
    apply(mk(0, 0, 0, 0, 0, 0,  0, 0, 2, 3, 5, 1, 0));
    @(negedge clk);
    bus.sensor_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid-reset sensor_ready", MATRIX_W'(bus.sensor_ready), MATRIX_W'(1));
    check_outs(mk(0, 0, 0, 0, 0, 0,  1, 0, 0, -1, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(0, 0, 1, 1, 1, 0,  1, 0, 0, -1, 0, 0, 0));
    apply(mk(0, 0, 0, 0, 1, 0,  1, 0, 0, -1, 0, 0, 0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
